// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
// Holds converter sizing, the overflow ceiling, FSM state encoding and the
// active-low seven-segment patterns (bit0 = segment a ... bit6 = segment g).
package bcd_pkg;

   localparam int unsigned DATA_W = 30;
   localparam int unsigned DIGITS = 9;
   localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(999_999_999);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/binary_bcd_behav_if.sv
// Converter bus: run request and binary value in, nine BCD digits plus
// done/overflow flags out.
//   master : drives enable/data, observes results
//   slave  : the converter
interface binary_bcd_behav_if;
   import bcd_pkg::*;

   logic              enable;
   logic [DATA_W-1:0] data;
   logic [3:0]        BCD0;
   logic [3:0]        BCD1;
   logic [3:0]        BCD2;
   logic [3:0]        BCD3;
   logic [3:0]        BCD4;
   logic [3:0]        BCD5;
   logic [3:0]        BCD6;
   logic [3:0]        BCD7;
   logic [3:0]        BCD8;
   logic              done;
   logic              overflow;

   modport master (
      output enable, data,
      input  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7, BCD8,
      input  done, overflow
   );

   modport slave (
      input  enable, data,
      output BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7, BCD8,
      output done, overflow
   );

endinterface

// File: rtl/bcd_2_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
//   bcd    : input digit code; 10..15 blank the display (4'b1111 is the mux blank code)
//   a_to_g : segment drive, bit0 = a ... bit6 = g, 0 = lit
module bcd_2_7seg
   import bcd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] a_to_g
);

   always_comb begin
      a_to_g = SEG_BLANK;
      case (bcd)
         4'd0:    a_to_g = SEG_0;
         4'd1:    a_to_g = SEG_1;
         4'd2:    a_to_g = SEG_2;
         4'd3:    a_to_g = SEG_3;
         4'd4:    a_to_g = SEG_4;
         4'd5:    a_to_g = SEG_5;
         4'd6:    a_to_g = SEG_6;
         4'd7:    a_to_g = SEG_7;
         4'd8:    a_to_g = SEG_8;
         4'd9:    a_to_g = SEG_9;
         default: a_to_g = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/binary_bcd_behav.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
//   CLOCK_50 : clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : slave side of binary_bcd_behav_if
//              enable   - run request, conversions repeat while high
//              data     - binary value, sampled at the capture edge only
//              BCD0..8  - registered digits, BCD0 least significant
//              done     - one-cycle pulse when the digits have just updated
//              overflow - set when the converted value exceeded MAX_VAL
module binary_bcd_behav #(
   parameter int unsigned DATA_W = bcd_pkg::DATA_W,
   parameter int unsigned DIGITS = bcd_pkg::DIGITS
) (
   input logic              CLOCK_50,
   input logic              reset,
   binary_bcd_behav_if.slave bus
);

   localparam int unsigned ACC_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'd9}};

   bcd_pkg::state_t   r_state, w_state_nx;
   logic [DATA_W-1:0] r_shift, w_shift_nx, w_shift_sh;
   logic [ACC_W-1:0]  r_acc, w_acc_nx, w_acc_adj, w_acc_sh;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic              r_over, w_over_nx;
   logic [ACC_W-1:0]  r_bcd, w_bcd_nx;
   logic              r_done, w_done_nx;
   logic              r_overflow, w_overflow_nx;

   // Add-3 correction on every nibble that would exceed 9 after doubling
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign w_acc_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? r_acc[4*g +: 4] + 4'd3
                                                            : r_acc[4*g +: 4];
   end

   // {accumulator, shift register} shifted left by one after correction
   assign w_acc_sh   = {w_acc_adj[ACC_W-2:0], r_shift[DATA_W-1]};
   assign w_shift_sh = {r_shift[DATA_W-2:0], 1'b0};

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state    <= bcd_pkg::S_IDLE;
         r_shift    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_over     <= 1'b0;
         r_bcd      <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_shift    <= w_shift_nx;
         r_acc      <= w_acc_nx;
         r_cnt      <= w_cnt_nx;
         r_over     <= w_over_nx;
         r_bcd      <= w_bcd_nx;
         r_done     <= w_done_nx;
         r_overflow <= w_overflow_nx;
      end
   end

   // Next-state and output logic
   always_comb begin
      w_state_nx    = r_state;
      w_shift_nx    = r_shift;
      w_acc_nx      = r_acc;
      w_cnt_nx      = r_cnt;
      w_over_nx     = r_over;
      w_bcd_nx      = r_bcd;
      w_done_nx     = 1'b0;
      w_overflow_nx = r_overflow;

      case (r_state)
         bcd_pkg::S_IDLE: begin
            if (bus.enable) begin
               w_shift_nx = bus.data;
               w_acc_nx   = '0;
               w_cnt_nx   = CNT_W'(DATA_W);
               w_over_nx  = (bus.data > bcd_pkg::MAX_VAL);
               w_state_nx = bcd_pkg::S_SHIFT;
            end
         end
         bcd_pkg::S_SHIFT: begin
            if (!bus.enable) begin
               // Abort: previous results stay, no done pulse
               w_state_nx = bcd_pkg::S_IDLE;
            end else begin
               w_acc_nx   = w_acc_sh;
               w_shift_nx = w_shift_sh;
               w_cnt_nx   = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  // Final shift: publish all digits on this same edge
                  w_bcd_nx      = r_over ? ALL_NINES : w_acc_sh;
                  w_overflow_nx = r_over;
                  w_done_nx     = 1'b1;
                  w_state_nx    = bcd_pkg::S_IDLE;
               end
            end
         end
         default: w_state_nx = bcd_pkg::S_IDLE;
      endcase
   end

   assign bus.BCD0     = r_bcd[3:0];
   assign bus.BCD1     = r_bcd[7:4];
   assign bus.BCD2     = r_bcd[11:8];
   assign bus.BCD3     = r_bcd[15:12];
   assign bus.BCD4     = r_bcd[19:16];
   assign bus.BCD5     = r_bcd[23:20];
   assign bus.BCD6     = r_bcd[27:24];
   assign bus.BCD7     = r_bcd[31:28];
   assign bus.BCD8     = r_bcd[35:32];
   assign bus.done     = r_done;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_binary_bcd_behav.sv
// Self-checking bench for binary_bcd_behav and bcd_2_7seg.
module tb_binary_bcd_behav;

   logic CLOCK_50 = 1'b0;
   logic reset;
   logic [3:0] seg_in;
   logic [6:0] seg_out;
   int n_checks = 0;
   int n_err    = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   binary_bcd_behav_if u_if ();

   binary_bcd_behav u_dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (u_if.slave)
   );

   bcd_2_7seg u_seg (
      .bcd    (seg_in),
      .a_to_g (seg_out)
   );

   // Decimal digits of v, units first; anything above 999,999,999 shows all nines
   function automatic logic [35:0] ref_digits(input longint v);
      logic [35:0] res;
      longint      t;
      res = '0;
      if (v > 64'd999_999_999) begin
         for (int i = 0; i < 9; i++) res[4*i +: 4] = 4'd9;
      end else begin
         t = v;
         for (int i = 0; i < 9; i++) begin
            res[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
      return res;
   endfunction

   function automatic logic [35:0] dut_digits();
      return {u_if.BCD8, u_if.BCD7, u_if.BCD6, u_if.BCD5, u_if.BCD4,
              u_if.BCD3, u_if.BCD2, u_if.BCD1, u_if.BCD0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [29:0] v);
      @(negedge CLOCK_50);
      u_if.data   = v;
      u_if.enable = 1'b1;
   endtask

   // Wait for done, check latency and results, then drive the next inputs
   // and confirm done drops after exactly one cycle.
   task automatic wait_done(input string tag, input longint v, input int exp_lat,
                            input logic keep_en, input logic [29:0] next_data);
      int k    = 0;
      bit seen = 0;
      while (k < 40 && !seen) begin
         @(negedge CLOCK_50);
         k++;
         if (u_if.done === 1'b1) seen = 1;
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         check({tag, "_latency"}, 64'(k), 64'(exp_lat));
         check({tag, "_digits"}, 64'(dut_digits()), 64'(ref_digits(v)));
         check({tag, "_overflow"}, 64'(u_if.overflow), 64'(v > 64'd999_999_999));
      end
      u_if.enable = keep_en;
      u_if.data   = next_data;
      @(negedge CLOCK_50);
      check({tag, "_done_width"}, 64'(u_if.done), 64'd0);
   endtask

   string seg_lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   initial begin
      int           done_cnt;
      logic [29:0]  rv;
      logic [6:0]   seg_exp;

      reset       = 1'b1;
      u_if.enable = 1'b0;
      u_if.data   = '0;
      seg_in      = '0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_digits", 64'(dut_digits()), 64'd0);
      check("rst_done", 64'(u_if.done), 64'd0);
      check("rst_overflow", 64'(u_if.overflow), 64'd0);
      reset = 1'b0;

      // Zero
      start(30'd0);
      wait_done("zero", 0, 31, 1'b0, 30'd0);

      // Data changing after capture must not matter
      start(30'd123_456_789);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      u_if.data = 30'd5;
      wait_done("seq", 123_456_789, 29, 1'b0, 30'd0);

      // Back-to-back: limit value then first overflowing value
      start(30'd999_999_999);
      wait_done("max", 999_999_999, 31, 1'b1, 30'd1_000_000_000);
      wait_done("ovf", 1_000_000_000, 30, 1'b0, 30'd0);

      // Abort leaves the previous result in place
      start(30'd42);
      wait_done("v42", 42, 31, 1'b0, 30'd0);
      start(30'd777);
      repeat (10) @(negedge CLOCK_50);
      u_if.enable = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLOCK_50);
         if (u_if.done === 1'b1) done_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_digits", 64'(dut_digits()), 64'(ref_digits(42)));

      // Reset mid-conversion, enable still high on the reset edge
      start(30'd555_555_555);
      repeat (15) @(negedge CLOCK_50);
      reset = 1'b1;
      @(negedge CLOCK_50);
      check("midrst_digits", 64'(dut_digits()), 64'd0);
      check("midrst_done", 64'(u_if.done), 64'd0);
      check("midrst_overflow", 64'(u_if.overflow), 64'd0);
      reset       = 1'b0;
      u_if.enable = 1'b0;
      @(negedge CLOCK_50);
      check("midrst_idle", 64'(dut_digits()), 64'd0);
      start(30'd1);
      wait_done("one", 1, 31, 1'b0, 30'd0);

      // Random values, some beyond the decimal range
      for (int i = 0; i < 8; i++) begin
         if (i % 3 == 0) rv = 30'($urandom);
         else            rv = 30'($urandom_range(999_999_999, 0));
         start(rv);
         wait_done($sformatf("rand%0d", i), longint'(rv), 31, 1'b0, 30'd0);
      end

      // Seven-segment decoder sweep
      for (int c = 0; c < 16; c++) begin
         seg_in = 4'(c);
         seg_exp = 7'h7F;
         if (c < 10) begin
            for (int j = 0; j < seg_lit[c].len(); j++)
               seg_exp[seg_lit[c][j] - "a"] = 1'b0;
         end
         #1;
         check($sformatf("seg%0d", c), 64'(seg_out), 64'(seg_exp));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/binary_bcd_behav.md
# binary_bcd_behav

Sequential binary-to-BCD converter for the FIR demo display path. Accepts an unsigned binary count up to 999,999,999 and produces nine registered BCD digits (BCD0 = units … BCD8 = hundred-millions). The top level multiplexes these digits three at a time onto HEX2..HEX0 through the seven-segment decoder. Conversion is shift-and-add-3 (double dabble), one input bit per clock.

## Interface
Parameters:
- DATA_W, 30: binary input width; 30 bits covers 999,999,999.
- DIGITS, 9: BCD digit count. Fixed; it matches the nine digit ports.

Ports:
- CLOCK_50, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: run request; while high, conversions repeat back-to-back.
- data, input, DATA_W: unsigned binary value; sampled only at the capture edge.
- BCD0..BCD8, output, 4 each: registered digits; BCD0 is least significant.
- done, output, 1: one-cycle pulse when BCD0..BCD8 have just updated.
- overflow, output, 1: registered alongside the digits; 1 when the converted value exceeded 999,999,999.

## Operation
- FSM states are IDLE and SHIFT.
- IDLE, enable=1 at an edge: capture data into the shift register, clear the 36-bit BCD accumulator, set bit counter to DATA_W, and enter SHIFT.
  - Record over = (data > 999_999_999).
- IDLE, enable=0: hold all outputs.
- SHIFT cycle:
  - First, each accumulator nibble ≥5 gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - Then the counter decrements.
- When the final (DATA_W-th) shift completes, the same edge:
  - loads BCD0..BCD8 from the accumulator, or all 4'd9 if over;
  - sets overflow = over and done = 1;
  - returns to IDLE.
- done is 0 on every other cycle.
- The digit outputs are never partially updated; all nine change on the same edge.
- enable falling during SHIFT: abort at that edge and return to IDLE. Outputs keep their previous values and done does not pulse.
- data changes after the capture edge are ignored.
- Digit range is 0..9 only; codes 10..15 are never produced.

## Timing
- Reset values: BCD0..BCD8 = 0, done = 0, overflow = 0, state IDLE, counter 0. Reset overrides enable on the same edge.
- Reset asserted mid-conversion discards the conversion. Outputs go to 0 at that edge.
- Latency: capture at edge E; digits, overflow and done valid after edge E+DATA_W (E+30).
- done is high only during the cycle after edge E+30.
- With enable held high, the next capture happens at edge E+31. Throughput is one result per 31 cycles.
- Shifter, accumulator and counter have no combinational path to the outputs; all outputs are flops.

## Structure
- Shared package bcd_pkg holds:
  - DATA_W, DIGITS and MAX_VAL = 999_999_999;
  - the seven-segment constants SEG_BLANK = 7'b1111111 and the digit patterns 0–9, active-low, bit0 = segment a … bit6 = segment g (0 = 7'b1000000).
- Natural sub-module: bcd_2_7seg. It is combinational, with input bcd[3:0] and output a_to_g[6:0].
  - Codes 0–9 map to the package digit patterns.
  - Codes 10–15 map to SEG_BLANK; the display multiplexer uses 4'b1111 as its blank code.
- The converter instantiates no other modules. The add-3 correction is a generate loop over the nine nibbles.

## Test plan
- Reset, then enable=1 with data=0: after 30 cycles done pulses, all BCD digits read 0, and overflow=0.
- data=123,456,789: BCD8..BCD0 = 1,2,3,4,5,6,7,8,9 with done exactly one cycle wide. Change data to 5 two cycles after capture; the result is unchanged.
- data=999,999,999, then 1,000,000,000, back-to-back with enable held high:
  - first result: all nines, overflow=0;
  - second result, 31 cycles later: all nines, overflow=1.
- Complete a conversion of 42, then start one of 777 and deassert enable at cycle 10: no done pulse, and the digits stay at …0,4,2.
- Assert reset at cycle 15 of a conversion: the next edge shows all digits 0, done=0, IDLE. A new capture with 1 gives BCD0=1 after 30 cycles.
- bcd_2_7seg sweep, codes 0..15: 0 gives 7'b1000000, 8 gives 7'b0000000, and 10..15 give 7'b1111111.
